// File: rtl/inc_dec_sequencer.sv
// inc_dec_sequencer: clocked microcode sequencer for INC/DEC r, (HL) and rr.
// Define INCDEC_RR_EN to build the 16-bit INC/DEC rr path.
module inc_dec_sequencer #(
    parameter int REG8_W     = 8,
    parameter int REG16_W    = 6,
    parameter int ALU_CTRL_W = 7,
    parameter int HL_INDEX   = 2
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset_n,
    input  logic                  i_Start,
    input  logic [7:0]            i_Opcode,
    input  logic                  i_Wait,
    input  logic                  i_Flush,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_Illegal,
    output logic [3:0]            o_Cycle_Step,
    output logic [2:0]            o_Cycle_Count,
    output logic                  o_IR_Fetch,
    output logic [REG8_W-1:0]     o_Read8,
    output logic [REG8_W-1:0]     o_Write8,
    output logic [REG16_W-1:0]    o_Read16,
    output logic [REG16_W-1:0]    o_Write16,
    output logic [1:0]            o_ReadALU8,
    output logic [1:0]            o_WriteALU8,
    output logic                  o_Move_Reg,
    output logic                  o_Bus_In,
    output logic                  o_Bus_Out,
    output logic                  o_Address_Out,
    output logic [ALU_CTRL_W-1:0] o_ALU_Control,
    output logic                  o_IDU_Inc,
    output logic                  o_IDU_Dec
);

    localparam int MDR = 6;

    typedef enum logic [2:0] {
        S_IDLE, S_R8, S_HL_RD, S_HL_MOD, S_HL_WR, S_RR_IDU, S_RR_FIN
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] step_q, step_d;
    logic [2:0] r_q;
    logic       dec_q;
    logic       illegal_q, illegal_d;
    logic       capture;
    logic       r8_op, rr_op, last, hold;

    logic [REG8_W-1:0]     r_hot;
    logic [ALU_CTRL_W-1:0] alu_word;

    assign r8_op = (i_Opcode[7:6] == 2'b00) && (i_Opcode[2:1] == 2'b10);
    assign last  = (step_q == 2'd3);
    // Bus M-cycles stretch T2 until memory is ready.
    assign hold  = ((state_q == S_HL_RD) || (state_q == S_HL_WR))
                   && (step_q == 2'd2) && i_Wait;

    assign r_hot    = REG8_W'(1) << r_q;
    assign alu_word = ALU_CTRL_W'({1'b1, 3'b000, dec_q, 1'b1, 1'b0});

`ifdef INCDEC_RR_EN
    logic [1:0]         pp_q;
    logic [REG16_W-1:0] pp_hot;

    assign rr_op  = (i_Opcode[7:6] == 2'b00) && (i_Opcode[2:0] == 3'b011);
    assign pp_hot = REG16_W'(1) << pp_q;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) pp_q <= 2'd0;
        else if (capture) pp_q <= i_Opcode[5:4];
    end
`else
    assign rr_op = 1'b0;
`endif

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q   <= S_IDLE;
            step_q    <= 2'd0;
            r_q       <= 3'd0;
            dec_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            illegal_q <= illegal_d;
            if (capture) begin
                r_q   <= i_Opcode[5:3];
                dec_q <= r8_op ? i_Opcode[0] : i_Opcode[3];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        illegal_d = 1'b0;
        capture   = 1'b0;
        if (state_q == S_IDLE) begin
            step_d = 2'd0;
            if (i_Start && !i_Flush) begin
                if (r8_op) begin
                    capture = 1'b1;
                    state_d = (i_Opcode[5:3] == 3'b110) ? S_HL_RD : S_R8;
                end else if (rr_op) begin
                    capture = 1'b1;
                    state_d = S_RR_IDU;
                end else begin
                    illegal_d = 1'b1;
                end
            end
        end else if (i_Flush) begin
            state_d = S_IDLE;
            step_d  = 2'd0;
        end else if (!hold) begin
            step_d = step_q + 2'd1;
            if (last) begin
                case (state_q)
                    S_HL_RD:  state_d = S_HL_MOD;
                    S_HL_MOD: state_d = S_HL_WR;
                    S_RR_IDU: state_d = S_RR_FIN;
                    default:  state_d = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        o_Busy        = (state_q != S_IDLE);
        o_Illegal     = illegal_q;
        o_Cycle_Step  = o_Busy ? (4'b0001 << step_q) : 4'b0000;
        o_Cycle_Count = 3'b000;
        o_Done        = 1'b0;
        o_IR_Fetch    = 1'b0;
        o_Read8       = '0;
        o_Write8      = '0;
        o_Read16      = '0;
        o_Write16     = '0;
        o_ReadALU8    = 2'b00;
        o_WriteALU8   = 2'b00;
        o_Move_Reg    = 1'b0;
        o_Bus_In      = 1'b0;
        o_Bus_Out     = 1'b0;
        o_Address_Out = 1'b0;
        o_ALU_Control = '0;
        o_IDU_Inc     = 1'b0;
        o_IDU_Dec     = 1'b0;
        case (state_q)
            S_R8: begin
                o_Cycle_Count = 3'b001;
                if (step_q == 2'd1) begin
                    o_Read8    = r_hot;
                    o_ReadALU8 = 2'b01;
                end
                if (step_q == 2'd2) begin
                    o_Write8      = r_hot;
                    o_WriteALU8   = 2'b01;
                    o_ALU_Control = alu_word;
                end
                if (last) begin
                    o_IR_Fetch = 1'b1;
                    o_Done     = 1'b1;
                end
            end
            S_HL_RD: begin
                o_Cycle_Count      = 3'b001;
                o_Read16[HL_INDEX] = 1'b1;
                o_Address_Out      = 1'b1;
                if (step_q == 2'd2) begin
                    o_Bus_In      = 1'b1;
                    o_Write8[MDR] = 1'b1;
                end
            end
            S_HL_MOD: begin
                o_Cycle_Count = 3'b010;
                if (step_q == 2'd1) begin
                    o_Read8[MDR] = 1'b1;
                    o_ReadALU8   = 2'b01;
                end
                if (step_q == 2'd2) begin
                    o_Write8[MDR] = 1'b1;
                    o_WriteALU8   = 2'b01;
                    o_ALU_Control = alu_word;
                end
            end
            S_HL_WR: begin
                o_Cycle_Count      = 3'b100;
                o_Read16[HL_INDEX] = 1'b1;
                o_Address_Out      = 1'b1;
                if (step_q == 2'd1) begin
                    o_Bus_Out    = 1'b1;
                    o_Move_Reg   = 1'b1;
                    o_Read8[MDR] = 1'b1;
                end
                if (last) begin
                    o_IR_Fetch = 1'b1;
                    o_Done     = 1'b1;
                end
            end
`ifdef INCDEC_RR_EN
            S_RR_IDU: begin
                o_Cycle_Count = 3'b001;
                if (step_q == 2'd1) o_Read16 = pp_hot;
                if (step_q == 2'd2) begin
                    o_Write16 = pp_hot;
                    o_IDU_Inc = !dec_q;
                    o_IDU_Dec = dec_q;
                end
            end
            S_RR_FIN: begin
                o_Cycle_Count = 3'b010;
                if (last) begin
                    o_IR_Fetch = 1'b1;
                    o_Done     = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_inc_dec_sequencer.sv
// tb_inc_dec_sequencer: randomized scoreboard bench for inc_dec_sequencer.
// Works with or without INCDEC_RR_EN defined.
module tb_inc_dec_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_Start, i_Wait, i_Flush;
    logic [7:0] i_Opcode;
    logic       o_Busy, o_Done, o_Illegal, o_IR_Fetch;
    logic [3:0] o_Cycle_Step;
    logic [2:0] o_Cycle_Count;
    logic [7:0] o_Read8, o_Write8;
    logic [5:0] o_Read16, o_Write16;
    logic [1:0] o_ReadALU8, o_WriteALU8;
    logic       o_Move_Reg, o_Bus_In, o_Bus_Out, o_Address_Out;
    logic [6:0] o_ALU_Control;
    logic       o_IDU_Inc, o_IDU_Dec;

    always #5 clk = ~clk;

    inc_dec_sequencer dut (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Start(i_Start),
        .i_Opcode(i_Opcode), .i_Wait(i_Wait), .i_Flush(i_Flush),
        .o_Busy(o_Busy), .o_Done(o_Done), .o_Illegal(o_Illegal),
        .o_Cycle_Step(o_Cycle_Step), .o_Cycle_Count(o_Cycle_Count),
        .o_IR_Fetch(o_IR_Fetch), .o_Read8(o_Read8), .o_Write8(o_Write8),
        .o_Read16(o_Read16), .o_Write16(o_Write16),
        .o_ReadALU8(o_ReadALU8), .o_WriteALU8(o_WriteALU8),
        .o_Move_Reg(o_Move_Reg), .o_Bus_In(o_Bus_In),
        .o_Bus_Out(o_Bus_Out), .o_Address_Out(o_Address_Out),
        .o_ALU_Control(o_ALU_Control),
        .o_IDU_Inc(o_IDU_Inc), .o_IDU_Dec(o_IDU_Dec)
    );

    // kind: 0 = completes, 1 = illegal, 2 = flushed
    typedef struct {
        int         kind;
        int         cycles;
        bit         is_hl;
        logic [7:0] rd8, wr8;
        logic [5:0] rd16, wr16;
        logic [6:0] alu;
        logic [2:0] mlast;
        int         bus_in, bus_out, addr, inc, dec, ralu, walu;
        int         rd8_at, alu_at, idu_at;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    logic [53:0] idle_vec;
    assign idle_vec = {o_Done, o_Cycle_Step, o_Cycle_Count, o_IR_Fetch,
                       o_Read8, o_Write8, o_Read16, o_Write16,
                       o_ReadALU8, o_WriteALU8, o_Move_Reg, o_Bus_In,
                       o_Bus_Out, o_Address_Out, o_ALU_Control,
                       o_IDU_Inc, o_IDU_Dec};

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, req,
                     $time);
        end
    endtask

    function automatic exp_t model(input logic [7:0] op, input int w1,
                                   input int w2, input int fk);
        exp_t e;
        bit   rr_en;
        bit   top0;
        int   r, pp;
`ifdef INCDEC_RR_EN
        rr_en = 1'b1;
`else
        rr_en = 1'b0;
`endif
        e = '{default: 0};
        top0 = (op[7:6] == 2'b00);
        r    = int'(op[5:3]);
        pp   = int'(op[5:4]);
        if (top0 && (op[2:0] == 3'd4 || op[2:0] == 3'd5)) begin
            e.alu  = (op[2:0] == 3'd5) ? 7'b1000110 : 7'b1000010;
            e.ralu = 1;
            e.walu = 1;
            if (r == 6) begin
                e.is_hl   = 1'b1;
                e.cycles  = 12 + w1 + w2;
                e.rd8     = 8'h40;
                e.wr8     = 8'h40;
                e.rd16    = 6'h04;
                e.bus_in  = 1 + w1;
                e.bus_out = 1;
                e.addr    = 8 + w1 + w2;
                e.rd8_at  = 6 + w1;
                e.alu_at  = 7 + w1;
                e.mlast   = 3'b100;
            end else begin
                e.cycles = 4;
                e.rd8    = 8'(1 << r);
                e.wr8    = 8'(1 << r);
                e.rd8_at = 2;
                e.alu_at = 3;
                e.mlast  = 3'b001;
            end
        end else if (rr_en && top0 && op[2:0] == 3'd3) begin
            e.cycles = 8;
            e.rd16   = 6'(1 << pp);
            e.wr16   = 6'(1 << pp);
            e.inc    = op[3] ? 0 : 1;
            e.dec    = op[3] ? 1 : 0;
            e.idu_at = 3;
            e.mlast  = 3'b010;
        end else begin
            e.kind   = 1;
            e.cycles = 0;
        end
        if (e.kind == 0 && fk > 0) begin
            e.kind   = 2;
            e.cycles = fk;
        end
        return e;
    endfunction

    // Monitor: accumulate what the DUT shows per sequence, compare at end.
    bit         act = 1'b0;
    int         cyc, bin, bout, mv, addr, inc, dec, ralu, walu;
    int         rd8_at, alu_at, idu_at;
    logic [7:0] a_rd8, a_wr8;
    logic [5:0] a_rd16, a_wr16;
    logic [6:0] a_alu;

    task automatic finish_seq(input int kind_obs);
        exp_t e;
        if (q.size() == 0) begin
            check("unexpected_seq", 64'(kind_obs), 64'hFF);
            return;
        end
        e = q.pop_front();
        check("kind", 64'(kind_obs), 64'(e.kind));
        if (kind_obs == 1) return;
        check("busy_cycles", 64'(cyc), 64'(e.cycles));
        if (e.kind != 0) return;
        check("read8", 64'(a_rd8), 64'(e.rd8));
        check("write8", 64'(a_wr8), 64'(e.wr8));
        check("read16", 64'(a_rd16), 64'(e.rd16));
        check("write16", 64'(a_wr16), 64'(e.wr16));
        check("alu_ctrl", 64'(a_alu), 64'(e.alu));
        check("bus_in_n", 64'(bin), 64'(e.bus_in));
        check("bus_out_n", 64'(bout), 64'(e.bus_out));
        check("move_reg_n", 64'(mv), 64'(e.bus_out));
        check("addr_n", 64'(addr), 64'(e.addr));
        check("idu_inc_n", 64'(inc), 64'(e.inc));
        check("idu_dec_n", 64'(dec), 64'(e.dec));
        check("ralu_n", 64'(ralu), 64'(e.ralu));
        check("walu_n", 64'(walu), 64'(e.walu));
        check("rd8_at", 64'(rd8_at), 64'(e.rd8_at));
        check("alu_at", 64'(alu_at), 64'(e.alu_at));
        check("idu_at", 64'(idu_at), 64'(e.idu_at));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_Busy) begin
                if (!act) begin
                    act = 1'b1;
                    cyc = 0; bin = 0; bout = 0; mv = 0; addr = 0;
                    inc = 0; dec = 0; ralu = 0; walu = 0;
                    rd8_at = 0; alu_at = 0; idu_at = 0;
                    a_rd8 = '0; a_wr8 = '0; a_rd16 = '0; a_wr16 = '0;
                    a_alu = '0;
                end
                cyc++;
                a_rd8  |= o_Read8;
                a_wr8  |= o_Write8;
                a_rd16 |= o_Read16;
                a_wr16 |= o_Write16;
                a_alu  |= o_ALU_Control;
                bin  += int'(o_Bus_In);
                bout += int'(o_Bus_Out);
                mv   += int'(o_Move_Reg);
                addr += int'(o_Address_Out);
                inc  += int'(o_IDU_Inc);
                dec  += int'(o_IDU_Dec);
                ralu += int'(o_ReadALU8 == 2'b01);
                walu += int'(o_WriteALU8 == 2'b01);
                if (rd8_at == 0 && o_Read8 != 0) rd8_at = cyc;
                if (alu_at == 0 && o_ALU_Control != 0) alu_at = cyc;
                if (idu_at == 0 && (o_IDU_Inc || o_IDU_Dec)) idu_at = cyc;
                if (o_Done) begin
                    check("done_step", 64'(o_Cycle_Step), 64'h8);
                    check("done_fetch", 64'(o_IR_Fetch), 64'h1);
                    if (q.size() > 0)
                        check("done_mcycle", 64'(o_Cycle_Count),
                              64'(q[0].mlast));
                    act = 1'b0;
                    finish_seq(0);
                end
            end else begin
                if (act) begin
                    act = 1'b0;
                    finish_seq(2);
                end
                check("idle_outputs", 64'(idle_vec), 64'h0);
            end
            if (o_Illegal) finish_seq(1);
        end
    end

    task automatic run_op(input logic [7:0] op, input int w1, input int w2,
                          input int fk);
        exp_t e;
        int   len;
        bit   wv;
        e = model(op, w1, w2, fk);
        q.push_back(e);
        len = (e.kind == 1) ? 1 : e.cycles;
        i_Start  = 1'b1;
        i_Opcode = op;
        @(posedge clk); #1;
        i_Start  = 1'b0;
        i_Opcode = 8'($urandom);
        for (int n = 1; n <= len; n++) begin
            if (e.is_hl)
                wv = (n >= 3 && n < 3 + w1) ||
                     (n >= 11 + w1 && n < 11 + w1 + w2);
            else
                wv = (e.kind != 1) && ($urandom_range(0, 1) == 1);
            i_Wait  = wv;
            i_Flush = (e.kind == 2) && (n == fk);
            if (n == len && e.kind == 0 && $urandom_range(0, 2) == 0) begin
                i_Start  = 1'b1;
                i_Opcode = 8'($urandom);
            end
            @(posedge clk); #1;
            i_Start = 1'b0;
        end
        i_Wait  = 1'b0;
        i_Flush = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] op;
        int         w1, w2, fk, len;
        exp_t       e;
        rst_n    = 1'b0;
        i_Start  = 1'b0;
        i_Opcode = 8'h00;
        i_Wait   = 1'b0;
        i_Flush  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(idle_vec), 64'h0);
        check("reset_busy", 64'(o_Busy), 64'h0);
        check("reset_illegal", 64'(o_Illegal), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        run_op(8'h04, 0, 0, 0);
        run_op(8'h35, 2, 0, 0);
        run_op(8'h3B, 0, 0, 0);
        run_op(8'h34, 0, 0, 6);
        run_op(8'h3D, 0, 0, 0);
        run_op(8'h76, 0, 0, 0);
        run_op(8'h34, 1, 3, 0);
        run_op(8'h03, 0, 0, 0);

        for (int i = 0; i < 160; i++) begin
            case ($urandom_range(0, 4))
                0, 1: op = {2'b00, 3'($urandom), 2'b10, 1'($urandom)};
                2:    op = {2'b00, 2'($urandom), 1'($urandom), 3'b011};
                3:    op = {2'b00, 3'b110, 2'b10, 1'($urandom)};
                default: op = 8'($urandom);
            endcase
            w1 = $urandom_range(0, 3);
            w2 = $urandom_range(0, 3);
            fk = 0;
            if ($urandom_range(0, 4) == 0) begin
                w1 = 0;
                w2 = 0;
                e = model(op, 0, 0, 0);
                len = e.cycles;
                if (e.kind == 0 && len > 1) fk = $urandom_range(1, len - 1);
            end
            run_op(op, w1, w2, fk);
        end

        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", 64'(q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inc_dec_sequencer.md
Name: inc_dec_sequencer

Overview:
Clocked successor to the combinational INC/DEC microcode decoder in the CPU control unit. It owns its own T-step/M-cycle sequencing and runs the whole 8-bit and 16-bit INC/DEC family from one start pulse: INC/DEC r, INC/DEC (HL) and INC/DEC rr. It drives the standard control-unit strobe buses and handles memory wait-states, flush, and illegal-opcode reporting. It sits beside the other per-family microcode blocks and is selected by the control unit's opcode dispatcher.

Parameters:
REG8_W, 8, width of the one-hot o_Read8/o_Write8 buses; bit k = r-code k (0=B,1=C,2=D,3=E,4=H,5=L,6=MDR,7=A).
REG16_W, 6, width of the one-hot o_Read16/o_Write16 buses; bit 0=BC,1=DE,2=HL,3=SP,4=PC,5=WZ.
ALU_CTRL_W, 7, width of o_ALU_Control.
HL_INDEX, 2, bit of the 16-bit buses used as the (HL) address source.

Ports:
i_Clk  in  1  system clock.
i_Reset_n  in  1  asynchronous, active-low reset.
i_Start  in  1  one-cycle pulse: latch i_Opcode and begin; ignored while o_Busy.
i_Opcode  in  8  opcode byte.
i_Wait  in  1  memory not ready; stalls bus M-cycles.
i_Flush  in  1  abort the current sequence.
o_Busy  out  1  sequence in progress.
o_Done  out  1  one-cycle pulse at the final T3.
o_Illegal  out  1  one-cycle pulse: opcode not in family.
o_Cycle_Step  out  4  one-hot T-step (bit n = Tn).
o_Cycle_Count  out  3  one-hot M-cycle (bit 0 = M1).
o_IR_Fetch  out  1  request next opcode fetch.
o_Read8, o_Write8  out  REG8_W  register-file 8-bit strobes.
o_Read16, o_Write16  out  REG16_W  register-pair strobes.
o_ReadALU8, o_WriteALU8  out  2  ALU operand/result strobes (bit 0 = accumulator-side port).
o_Move_Reg, o_Bus_In, o_Bus_Out, o_Address_Out  out  1  bus strobes.
o_ALU_Control  out  ALU_CTRL_W  ALU operation word.
o_IDU_Inc, o_IDU_Dec  out  1  16-bit incrementer/decrementer control.

Behaviour:
- Reset (async assert, sync deassert): state IDLE, step and M-cycle counters zero. Every output is 0, including o_Cycle_Step and o_Cycle_Count.
- Decode on i_Start:
  - 00rrr100 = INC r; 00rrr101 = DEC r; rrr=110 selects class HL.
  - 00pp0011 = INC rr; 00pp1011 = DEC rr.
  - Any other opcode: o_Illegal pulses on the next clock; state stays IDLE.
- States: IDLE, R8, HL_RD, HL_MOD, HL_WR, RR_IDU, RR_FIN. The step counter advances T0→T3 each clock and wraps to T0 at the next M-cycle.
- Strobes are combinational from registered state, so they are valid in the same cycle as o_Cycle_Step.
- R8 (1 M-cycle):
  - T1: o_Read8[r], o_ReadALU8[0].
  - T2: o_Write8[r], o_WriteALU8[0], o_ALU_Control = {1,000,dec,1,0}.
  - T3: o_IR_Fetch, o_Done; return to IDLE.
- HL (3 M-cycles):
  - HL_RD: o_Read16[HL_INDEX] and o_Address_Out held T0–T3; T2 o_Bus_In plus o_Write8[6].
  - HL_MOD: T1 o_Read8[6], o_ReadALU8[0]; T2 o_Write8[6], o_WriteALU8[0], ALU op as in R8.
  - HL_WR: o_Read16[HL_INDEX] and o_Address_Out held T0–T3; T1 o_Bus_Out, o_Move_Reg, o_Read8[6]; T3 o_IR_Fetch, o_Done.
- RR (2 M-cycles):
  - RR_IDU: T1 o_Read16[pp]; T2 o_Write16[pp] plus o_IDU_Inc or o_IDU_Dec.
  - RR_FIN: T3 o_IR_Fetch, o_Done. No ALU strobes, so flags are untouched.
- o_Busy is high from the clock after i_Start through the final T3 inclusive.
- Wait: i_Wait is sampled only at T2 of HL_RD and HL_WR. While it is high the step counter holds at T2 and the T2 strobes stay asserted. In other states i_Wait is ignored.
- Flush: on the next clock the block returns to IDLE with all outputs 0; no o_Done. Flush has priority over Wait.
- i_Start coincident with the final T3: ignored, because o_Busy is still high.
- Asynchronous reset mid-sequence aborts immediately; the sequence is not resumed.

Optional Feature:
INCDEC_RR_EN:
- Defined: the RR path and the o_IDU_Inc/o_IDU_Dec logic exist.
- Undefined: 16-bit opcodes decode as illegal; o_IDU_Inc, o_IDU_Dec and o_Write16 are tied to 0.

Test Plan:
- Reset held low, then release, with no start -> every output 0, o_Busy 0.
- i_Start, i_Opcode=0x04 (INC B) -> T1 o_Read8=0x01; T2 o_Write8=0x01, o_ALU_Control=0b1000010; T3 o_IR_Fetch=1, o_Done=1; 4 clocks total.
- 0x35 (DEC (HL)) with i_Wait high for 2 clocks at HL_RD T2 -> o_Bus_In held 3 cycles; HL_MOD T2 o_ALU_Control=0b1000110; HL_WR T1 o_Bus_Out=1; o_Done after 14 clocks.
- 0x3B (DEC SP) -> RR_IDU T2 o_Write16=0x08, o_IDU_Dec=1; o_Done at clock 8. Without INCDEC_RR_EN -> o_Illegal pulse, o_Busy stays 0.
- 0x34 (INC (HL)), i_Flush asserted at HL_MOD T1 -> next clock all outputs 0, no o_Done; a following i_Start with 0x3D (DEC A) completes normally, with o_Write8=0x80 at T2.
- 0x76 (HALT) -> o_Illegal=1 for one clock, no strobes asserted.
